// File: rtl/lsu_sequencer.sv
// Load/store sequencer: captures up to three slot requests at bundle issue and serializes them
// in slot order onto one req/ack memory port. Optional build macro: LSU_ALIGN_CHECK_EN.
module lsu_sequencer #(
    parameter int unsigned REG_W  = 6,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load_0,
    input  logic              is_store_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [1:0]        size_0,
    input  logic              sext_0,
    input  logic [REG_W-1:0]  dest_0,
    input  logic [31:0]       sdata_0,
    input  logic              is_load_1,
    input  logic              is_store_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [1:0]        size_1,
    input  logic              sext_1,
    input  logic [REG_W-1:0]  dest_1,
    input  logic [31:0]       sdata_1,
    input  logic              is_load_2,
    input  logic              is_store_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [1:0]        size_2,
    input  logic              sext_2,
    input  logic [REG_W-1:0]  dest_2,
    input  logic [31:0]       sdata_2,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_idx,
    output logic [31:0]       wb_val,
    output logic              err
);

    typedef enum logic [2:0] {StIdle, StCapture, StIssue, StWb, StNext, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        pend_q, pend_d;
    logic [2:0]        st_q;
    logic [2:0]        sext_q;
    logic [ADDR_W-1:0] addr_q  [3];
    logic [1:0]        size_q  [3];
    logic [REG_W-1:0]  dest_q  [3];
    logic [31:0]       sdata_q [3];
    logic [31:0]       rdata_q;
    logic [31:0]       ld_ext;
    logic [1:0]        cur;
    logic [2:0]        in_ld, in_st;

    assign in_ld = {is_load_2, is_load_1, is_load_0};
    assign in_st = {is_store_2, is_store_1, is_store_0};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= '0;
            sext_q <= '0;
            for (int k = 0; k < 3; k++) begin
                addr_q[k]  <= '0;
                size_q[k]  <= '0;
                dest_q[k]  <= '0;
                sdata_q[k] <= '0;
            end
        end else if (state_q == StIdle && start) begin
            st_q       <= in_st;
            sext_q     <= {sext_2, sext_1, sext_0};
            addr_q[0]  <= addr_0;
            addr_q[1]  <= addr_1;
            addr_q[2]  <= addr_2;
            size_q[0]  <= size_0;
            size_q[1]  <= size_1;
            size_q[2]  <= size_2;
            dest_q[0]  <= dest_0;
            dest_q[1]  <= dest_1;
            dest_q[2]  <= dest_2;
            sdata_q[0] <= sdata_0;
            sdata_q[1] <= sdata_1;
            sdata_q[2] <= sdata_2;
        end
    end

    // Lowest pending slot is the one in service (program order).
    always_comb begin
        if (pend_q[0])      cur = 2'd0;
        else if (pend_q[1]) cur = 2'd1;
        else                cur = 2'd2;
    end

    always_comb begin
        unique case (size_q[cur])
            2'd0:    ld_ext = {{24{sext_q[cur] & mem_rdata[7]}}, mem_rdata[7:0]};
            2'd1:    ld_ext = {{16{sext_q[cur] & mem_rdata[15]}}, mem_rdata[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic [2:0] mis;
    logic       err_q, err_d;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mis[k] = (size_q[k] == 2'd1 && addr_q[k][0]) ||
                     (size_q[k][1] && addr_q[k][1:0] != 2'b00);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
`ifdef LSU_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCapture;
                    pend_d  = in_ld | in_st;
`ifdef LSU_ALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StCapture: begin
`ifdef LSU_ALIGN_CHECK_EN
                pend_d = pend_q & ~mis;
                err_d  = |(pend_q & mis);
`endif
                state_d = (pend_d != 3'b000) ? StIssue : StDone;
            end
            StIssue: begin
                if (mem_ack) state_d = st_q[cur] ? StNext : StWb;
            end
            StWb: state_d = StNext;
            StNext: begin
                pend_d  = pend_q & ~(3'b001 << cur);
                state_d = (pend_d != 3'b000) ? StIssue : StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (state_q == StIssue && mem_ack && !st_q[cur]) rdata_q <= ld_ext;
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = (state_q == StDone) & err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_size  = '0;
        mem_wdata = '0;
        wb_valid  = 1'b0;
        wb_idx    = '0;
        wb_val    = '0;
        if (state_q == StIssue) begin
            mem_req  = 1'b1;
            mem_we   = st_q[cur];
            mem_addr = addr_q[cur];
            mem_size = size_q[cur];
            unique case (size_q[cur])
                2'd0:    mem_wdata = {24'h0, sdata_q[cur][7:0]};
                2'd1:    mem_wdata = {16'h0, sdata_q[cur][15:0]};
                default: mem_wdata = sdata_q[cur];
            endcase
        end
        if (state_q == StWb) begin
            wb_valid = 1'b1;
            wb_idx   = dest_q[cur];
            wb_val   = rdata_q;
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: directed bundles from the test plan plus randomized
// bundles, checked against a slot-level reference model with a wait-state memory responder.
module tb_lsu_sequencer;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [5:0]  dest;
        logic        sext;
        int          slot;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        il [3];
    logic        is [3];
    logic [31:0] ad [3];
    logic [1:0]  sz [3];
    logic        sx [3];
    logic [5:0]  ds [3];
    logic [31:0] sd [3];
    int          waits [3];
    logic [31:0] rtab [3];
    bit          use_tab;

    logic        busy, done, mem_req, mem_we, wb_valid, err;
    logic [31:0] mem_addr, mem_wdata, wb_val;
    logic [1:0]  mem_size;
    logic [5:0]  wb_idx;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_sequencer dut (
        .wb_clk_i(clk), .rst_n(rst_n), .start(start),
        .is_load_0(il[0]), .is_store_0(is[0]), .addr_0(ad[0]), .size_0(sz[0]),
        .sext_0(sx[0]), .dest_0(ds[0]), .sdata_0(sd[0]),
        .is_load_1(il[1]), .is_store_1(is[1]), .addr_1(ad[1]), .size_1(sz[1]),
        .sext_1(sx[1]), .dest_1(ds[1]), .sdata_1(sd[1]),
        .is_load_2(il[2]), .is_store_2(is[2]), .addr_2(ad[2]), .size_2(sz[2]),
        .sext_2(sx[2]), .dest_2(ds[2]), .sdata_2(sd[2]),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .err(err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_result(logic [31:0] r, logic [1:0] size, logic sext);
        longint unsigned v;
        if (size == 2'd0) begin
            v = r % 256;
            if (sext && v >= 128) v = v + 64'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = r % 65536;
            if (sext && v >= 32768) v = v + 64'hFFFF0000;
        end else begin
            v = r;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_data(logic [31:0] d, logic [1:0] size);
        longint unsigned v = d;
        if (size == 2'd0)      v = v % 256;
        else if (size == 2'd1) v = v % 65536;
        return v[31:0];
    endfunction

    function automatic bit misaligned(logic [31:0] a, logic [1:0] size);
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic clear_slots();
        for (int k = 0; k < 3; k++) begin
            il[k] = 0; is[k] = 0; ad[k] = '0; sz[k] = '0; sx[k] = 0; ds[k] = '0; sd[k] = '0;
            waits[k] = 0; rtab[k] = '0;
        end
        use_tab = 0;
    endtask

    task automatic run_bundle(input string name);
        req_t        exp_q[$];
        logic [37:0] wb_q[$];
        req_t        cur;
        req_t        r;
        logic [37:0] wexp;
        logic [66:0] held;
        bit          exp_err = 0;
        int          exp_done = 2;
        int          cyc = 0;
        int          wcnt = 0;
        bit          seen_done = 0;
        bit          prev_req = 0;
        bit          prev_ack = 0;

        for (int k = 0; k < 3; k++) begin
            if (il[k] || is[k]) begin
`ifdef LSU_ALIGN_CHECK_EN
                if (misaligned(ad[k], sz[k])) begin
                    exp_err = 1;
                    continue;
                end
`endif
                r.we = is[k]; r.addr = ad[k]; r.size = sz[k];
                r.wdata = store_data(sd[k], sz[k]); r.dest = ds[k]; r.sext = sx[k]; r.slot = k;
                exp_q.push_back(r);
                exp_done += waits[k] + (is[k] ? 2 : 3);
            end
        end

        @(posedge clk); #1;
        start = 1;
        cur = exp_q.size() > 0 ? exp_q[0] : r;
        while (!seen_done && cyc < 200) begin
            @(posedge clk); #1;
            start = 0;
            cyc++;
            mem_ack = 0;
            check({name, "_busy"}, busy, 1);
            if (mem_req) begin
                if (!prev_req || prev_ack) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_req"}, 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check({name, "_req"}, {mem_we, mem_addr, mem_size, mem_wdata},
                              {cur.we, cur.addr, cur.size, cur.wdata});
                    end
                    held = {mem_we, mem_addr, mem_size, mem_wdata};
                    wcnt = 0;
                end else begin
                    check({name, "_req_stable"}, {mem_we, mem_addr, mem_size, mem_wdata}, held);
                end
                if (wcnt >= waits[cur.slot]) begin
                    mem_ack = 1;
                    mem_rdata = use_tab ? rtab[cur.slot] : $urandom;
                    if (!cur.we) wb_q.push_back({cur.dest, load_result(mem_rdata, cur.size, cur.sext)});
                end
                wcnt++;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check({name, "_extra_wb"}, {wb_idx, wb_val}, 0);
                end else begin
                    wexp = wb_q.pop_front();
                    check({name, "_wb"}, {wb_idx, wb_val}, wexp);
                end
            end
            if (done) begin
                seen_done = 1;
                check({name, "_done_cycle"}, cyc, exp_done);
                check({name, "_err"}, err, exp_err);
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
        end
        mem_ack = 0;
        check({name, "_done_seen"}, seen_done, 1);
        check({name, "_reqs_left"}, exp_q.size(), 0);
        check({name, "_wbs_left"}, wb_q.size(), 0);
        @(posedge clk); #1;
        check({name, "_idle_after"}, {busy, done, mem_req, wb_valid}, 4'b0000);
    endtask

    initial begin
        int  cnt;
        bit  bad;

        clear_slots();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check("reset_outputs",
              {busy, done, mem_req, mem_we, mem_addr, mem_size, mem_wdata, wb_valid, wb_idx,
               wb_val, err}, '0);

        // No requests: done at cycle 2, no mem_req.
        clear_slots();
        run_bundle("empty");

        // Three zero-wait loads.
        clear_slots();
        use_tab = 1;
        il[0] = 1; ad[0] = 32'h100; sz[0] = 2'd0; sx[0] = 1; ds[0] = 6'd5; rtab[0] = 32'h000000F0;
        il[1] = 1; ad[1] = 32'h202; sz[1] = 2'd1; sx[1] = 0; ds[1] = 6'd6; rtab[1] = 32'h0000F00D;
        il[2] = 1; ad[2] = 32'h304; sz[2] = 2'd2; sx[2] = 0; ds[2] = 6'd7; rtab[2] = 32'h12345678;
        check("three_load_lb_model", load_result(rtab[0], sz[0], sx[0]), 32'hFFFFFFF0);
        run_bundle("three_loads");

        // Mixed store/load with three wait states each.
        clear_slots();
        use_tab = 1;
        is[0] = 1; ad[0] = 32'h10; sz[0] = 2'd0; sd[0] = 32'hAABBCCDD; waits[0] = 3;
        il[2] = 1; ad[2] = 32'h20; sz[2] = 2'd2; ds[2] = 6'd9; rtab[2] = 32'hCAFEBABE; waits[2] = 3;
        run_bundle("mixed_wait");

        // Load+store collision is a store.
        clear_slots();
        il[0] = 1; is[0] = 1; ad[0] = 32'h40; sz[0] = 2'd1; sd[0] = 32'h12348765; ds[0] = 6'd3;
        run_bundle("collision");

        // Alignment case.
        clear_slots();
        il[1] = 1; ad[1] = 32'h102; sz[1] = 2'd2; ds[1] = 6'd11;
        is[2] = 1; ad[2] = 32'h200; sz[2] = 2'd2; sd[2] = 32'h55AA55AA;
        run_bundle("align");

        // Reset during an outstanding request.
        clear_slots();
        for (int k = 0; k < 3; k++) begin
            il[k] = 1; ad[k] = 32'h400 + 4 * k; sz[k] = 2'd2; waits[k] = 2;
        end
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        cnt = 0;
        while (!mem_req && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("rst_reach_req", mem_req, 1);
        rst_n = 0;
        #1;
        check("rst_mid_outputs", {mem_req, busy, wb_valid}, 3'b000);
        @(posedge clk); #1 rst_n = 1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy || mem_req || wb_valid) bad = 1;
        end
        check("rst_no_done", bad, 0);

        // Randomized bundles.
        for (int n = 0; n < 40; n++) begin
            clear_slots();
            for (int k = 0; k < 3; k++) begin
                il[k] = ($urandom_range(0, 2) != 0);
                is[k] = ($urandom_range(0, 2) == 0);
                ad[k] = $urandom;
                if ($urandom_range(0, 3) != 0) ad[k][1:0] = 2'b00;
                sz[k] = 2'($urandom_range(0, 3));
                sx[k] = 1'($urandom_range(0, 1));
                ds[k] = 6'($urandom_range(0, 63));
                sd[k] = $urandom;
                waits[k] = $urandom_range(0, 3);
            end
            run_bundle($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Load/store sequencer for the three-slot VLIW core. At bundle issue it captures the load/store requests of execution units 0–2 and serializes them, in slot order, onto a single request/acknowledge memory port. It returns load results, sign- or zero-extended, to the register file through one writeback port. It sits between the execution units and the core's external memory interface and owns that port exclusively.

## Interface
Parameters:
- REG_W, 6, register index width (64 registers)
- ADDR_W, 32, address width

Ports (k = 0..2, one set per slot):
- wb_clk_i  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  bundle-issue pulse; captures all slot inputs
- is_load_k  in  1  slot k requests a load
- is_store_k  in  1  slot k requests a store
- addr_k  in  ADDR_W  slot k byte address
- size_k  in  2  0 = byte, 1 = half, 2 or 3 = word
- sext_k  in  1  sign-extend load result
- dest_k  in  REG_W  load destination register
- sdata_k  in  32  store data
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  request address
- mem_size  out  2  request size
- mem_wdata  out  32  store data, masked to size
- mem_ack  in  1  request completed; mem_rdata valid for loads
- mem_rdata  in  32  load data, right-aligned
- wb_valid  out  1  writeback strobe
- wb_idx  out  REG_W  writeback register
- wb_val  out  32  writeback value
- err  out  1  misaligned-slot flag (LSU_ALIGN_CHECK_EN only)

## Operation
- All outputs reset to 0. Internal pending mask and state reset to IDLE.
- State machine:
  - IDLE → CAPTURE on `start`.
  - CAPTURE → ISSUE if the pending mask is non-zero, else → DONE.
  - ISSUE holds `mem_req` with the lowest pending slot's fields.
  - ISSUE → WB on `mem_ack` for a load; → NEXT on `mem_ack` for a store.
  - WB → NEXT.
  - NEXT clears the slot's pending bit, then goes to ISSUE if bits remain, else to DONE.
  - DONE → IDLE.
- Pending mask bit k = is_load_k | is_store_k, captured at `start`. A slot with both bits set is a store only.
- Service order is strictly slot 0, then 1, then 2 (program order). There is never more than one outstanding request.
- `mem_wdata`: sdata masked to the low 8, 16 or 32 bits according to size. Upper bits are 0.
- Load result:
  - Take the low 8, 16 or 32 bits of `mem_rdata`.
  - If sext is set, sign-extend from bit 7 or 15; otherwise zero-extend. Word loads pass through unchanged.
- `start` while `busy` is ignored. Inputs are only sampled on the `start` cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_size` and `mem_wdata` are stable while `mem_req` is high. `mem_req` drops the cycle after `mem_ack` is sampled.
- `mem_ack` while `mem_req` is low is ignored.
- Reset asserted mid-sequence clears everything asynchronously. `mem_req` drops immediately and no writeback or done is produced.

## Timing
- Cycle 0: `start` sampled. Cycle 1: CAPTURE, `busy` = 1.
- Cycle 2: first `mem_req`.
- With zero-wait acknowledge:
  - Store: 2 cycles per slot (ISSUE, NEXT).
  - Load: 3 cycles per slot (ISSUE, WB, NEXT). `wb_valid` is high exactly one cycle, in WB.
- `done` is high for one cycle in DONE. `busy` is high from CAPTURE through DONE inclusive.
- No requests: `done` in cycle 2.
- Three zero-wait loads: `done` in cycle 11.
- Wait states extend ISSUE one cycle per cycle without `mem_ack`.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - At CAPTURE, a slot is misaligned if it is a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - A misaligned slot's pending bit is cleared, so it is never issued and gets no writeback.
  - `err` is high concurrently with `done` if any slot was misaligned.
- LSU_ALIGN_CHECK_EN undefined:
  - No check. Addresses are issued unmodified.
  - `err` is tied 0.

## Test plan
- Reset/idle:
  - After `rst_n` deasserts, all outputs are 0.
  - `start` with no requests → `done` at cycle 2, `mem_req` never asserted.
- Three loads, zero-wait acknowledge:
  - Slots request lb sext @0x100, lh zext @0x202, lw @0x304; mem_rdata = 0x000000F0, 0x0000F00D, 0x12345678.
  - Required writebacks: 0xFFFFFFF0, 0x0000F00D, 0x12345678, to dest 5, 6, 7 in that order; `done` at cycle 11.
- Mixed sequence with wait states:
  - Slot 0 = sb 0xAABBCCDD @0x10, slot 1 idle, slot 2 = lw @0x20; `mem_ack` delayed 3 cycles for each request.
  - Required: `mem_wdata` = 0x000000DD with `mem_we` = 1; slot 1 skipped; each request held stable until ack.
  - Required: `wb_valid` only for slot 2.
- Load+store collision: slot 0 has both is_load and is_store set → only a store is issued and `wb_valid` never asserts.
- Reset mid-request: deassert `rst_n` while `mem_req` = 1 → `mem_req`, `busy` and `wb_valid` go to 0 immediately, and no `done` follows.
- Alignment (LSU_ALIGN_CHECK_EN defined): lw @0x102 in slot 1, sw @0x200 in slot 2 → only the slot 2 store is issued; `err` = 1 together with `done`. With the macro undefined, both are issued and `err` = 0.
